// File: rtl/csr_cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_cnt_pkg
// Description : Shared constants and types for the counter CSR access unit.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_cnt_pkg;

    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam logic [1:0] OP_RSVD = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_WRITE   = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    typedef enum logic {
        CNT_CYC = 1'b0,
        CNT_RET = 1'b1
    } cnt_sel_e;

endpackage
`default_nettype wire

// File: rtl/csr_counter_access_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter_access_if
// Description : Request/response bus between execute stage and counter CSR unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_counter_access_if #(
    parameter int XLEN = 32
) ();
    logic            req_valid;
    logic            req_ready;
    logic [11:0]     req_addr;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_wdata;
    logic            req_wr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_illegal;

    modport slave (
        input  req_valid, req_addr, req_op, req_wdata, req_wr, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_illegal
    );

    modport master (
        output req_valid, req_addr, req_op, req_wdata, req_wr, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_illegal
    );
endinterface
`default_nettype wire

// File: rtl/csr_cnt_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : csr_cnt_addr_decode
// Description : Decodes CSR address/op/write-intent into counter and half select.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_cnt_addr_decode
    import csr_cnt_pkg::*;
(
    input  logic [11:0] addr,
    input  logic [1:0]  op,
    input  logic        wr,
    output cnt_sel_e    cnt_sel,
    output logic        hi_sel,
    output logic        read_only,
    output logic        illegal
);
    logic w_mapped;

    always_comb begin
        cnt_sel   = CNT_CYC;
        hi_sel    = 1'b0;
        read_only = 1'b0;
        w_mapped  = 1'b1;
        case (addr)
            CSR_MCYCLE:    begin end
            CSR_MCYCLEH:   hi_sel = 1'b1;
            CSR_MINSTRET:  cnt_sel = CNT_RET;
            CSR_MINSTRETH: begin cnt_sel = CNT_RET; hi_sel = 1'b1; end
            CSR_CYCLE:     read_only = 1'b1;
            CSR_CYCLEH:    begin read_only = 1'b1; hi_sel = 1'b1; end
            CSR_INSTRET:   begin read_only = 1'b1; cnt_sel = CNT_RET; end
            CSR_INSTRETH:  begin read_only = 1'b1; cnt_sel = CNT_RET; hi_sel = 1'b1; end
            default:       w_mapped = 1'b0;
        endcase
        illegal = !w_mapped || (op == OP_RSVD) || (read_only && wr);
    end
endmodule
`default_nettype wire

// File: rtl/csr_counter_access.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter_access
// Description : Read/modify/write access unit for the 64-bit cycle/instret counters.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_counter_access
    import csr_cnt_pkg::*;
#(
    parameter int COUNT_LEN = 64,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    csr_counter_access_if.slave  bus,
    input  logic [COUNT_LEN-1:0] cyc_value,
    input  logic [COUNT_LEN-1:0] ret_value,
    output logic                 cyc_wr_en,
    output logic                 ret_wr_en,
    output logic [COUNT_LEN-1:0] cnt_wr_data
);
    state_e          state_q,   state_d;
    logic [11:0]     addr_q,    addr_d;
    logic [1:0]      op_q,      op_d;
    logic [XLEN-1:0] wdata_q,   wdata_d;
    logic            wr_q,      wr_d;
    logic [XLEN-1:0] new_q,     new_d;
    logic [XLEN-1:0] rdata_q,   rdata_d;
    logic            illegal_q, illegal_d;

    cnt_sel_e           w_sel;
    logic               w_hi;
    logic               w_ro;
    logic               w_illegal;
    logic [COUNT_LEN-1:0] w_live;
    logic [XLEN-1:0]    w_old;
    logic               w_wr_fire;

    // Decode runs off the latched request, so it stays valid through WRITE.
    csr_cnt_addr_decode u_decode (
        .addr      (addr_q),
        .op        (op_q),
        .wr        (wr_q),
        .cnt_sel   (w_sel),
        .hi_sel    (w_hi),
        .read_only (w_ro),
        .illegal   (w_illegal)
    );

    assign w_live = (w_sel == CNT_RET) ? ret_value : cyc_value;
    assign w_old  = w_hi ? w_live[COUNT_LEN-1:XLEN] : w_live[XLEN-1:0];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        op_d      = op_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        new_d     = new_q;
        rdata_d   = rdata_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    op_d    = bus.req_op;
                    wdata_d = bus.req_wdata;
                    wr_d    = bus.req_wr;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                rdata_d   = w_illegal ? '0 : w_old;
                illegal_d = w_illegal;
                case (op_q)
                    OP_RW:   new_d = wdata_q;
                    OP_RS:   new_d = w_old | wdata_q;
                    OP_RC:   new_d = w_old & ~wdata_q;
                    default: new_d = w_old;
                endcase
                state_d = (!w_illegal && !w_ro && wr_q) ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            op_q      <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            new_q     <= '0;
            rdata_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            op_q      <= op_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            new_q     <= new_d;
            rdata_q   <= rdata_d;
            illegal_q <= illegal_d;
        end
    end

    // Outputs are gated by rst so nothing leaks out during the reset cycle.
    assign w_wr_fire       = (state_q == ST_WRITE) && !rst;
    assign cyc_wr_en       = w_wr_fire && (w_sel == CNT_CYC);
    assign ret_wr_en       = w_wr_fire && (w_sel == CNT_RET);
    assign cnt_wr_data     = !w_wr_fire ? '0 :
                             w_hi ? {new_q, w_live[XLEN-1:0]} :
                                    {w_live[COUNT_LEN-1:XLEN], new_q};
    assign bus.req_ready   = (state_q == ST_IDLE) && !rst;
    assign bus.rsp_valid   = (state_q == ST_RESP) && !rst;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_illegal = illegal_q;
endmodule
`default_nettype wire

// File: tb/tb_csr_counter_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_counter_access
// Description : Scoreboard bench for csr_counter_access with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_counter_access;

    typedef struct packed { logic [31:0] rdata; logic illegal; } rsp_t;
    typedef struct packed { logic is_ret; logic [63:0] data; } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] cyc_value, ret_value, cnt_wr_data;
    logic        cyc_wr_en, ret_wr_en;

    always #5 clk = ~clk;

    csr_counter_access_if #(.XLEN(32)) bus ();

    csr_counter_access #(.COUNT_LEN(64), .XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .cyc_value   (cyc_value),
        .ret_value   (ret_value),
        .cyc_wr_en   (cyc_wr_en),
        .ret_wr_en   (ret_wr_en),
        .cnt_wr_data (cnt_wr_data)
    );

    rsp_t        rsp_q[$];
    wr_t         wr_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc_n   = 0;
    int          hold_cnt = 0;
    bit          force_ready = 1'b0;
    int          last_hs = 0;
    bit          last_wr = 1'b0;
    logic [11:0] addrs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural CSR semantics over the eight-entry map.
    function automatic void model(input logic [11:0] addr, input logic [1:0] op,
                                  input logic wr, input logic [31:0] wd,
                                  input logic [63:0] a_cyc, input logic [63:0] a_ret,
                                  input logic [63:0] b_cyc, input logic [63:0] b_ret,
                                  output rsp_t r, output bit do_wr, output wr_t w);
        bit          mapped = 1, ro = 0, is_ret = 0, hi = 0, illegal;
        logic [63:0] a, b;
        logic [31:0] old, nv;
        case (addr)
            12'hB00: begin end
            12'hB80: hi = 1;
            12'hB02: is_ret = 1;
            12'hB82: begin is_ret = 1; hi = 1; end
            12'hC00: ro = 1;
            12'hC80: begin ro = 1; hi = 1; end
            12'hC02: begin ro = 1; is_ret = 1; end
            12'hC82: begin ro = 1; is_ret = 1; hi = 1; end
            default: mapped = 0;
        endcase
        illegal = !mapped || (op == 2'b00) || (ro && wr);
        a   = is_ret ? a_ret : a_cyc;
        b   = is_ret ? b_ret : b_cyc;
        old = hi ? a[63:32] : a[31:0];
        case (op)
            2'b01:   nv = wd;
            2'b10:   nv = old | wd;
            default: nv = old & ~wd;
        endcase
        r.rdata   = illegal ? 32'h0 : old;
        r.illegal = illegal;
        do_wr     = !illegal && wr;
        w.is_ret  = is_ret;
        w.data    = hi ? {nv, b[31:0]} : {b[63:32], nv};
    endfunction

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(posedge clk) begin
        #1;
        if (hold_cnt > 0) begin
            bus.rsp_ready = 1'b0;
            hold_cnt--;
        end else if (force_ready) begin
            bus.rsp_ready = 1'b1;
        end else begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: strobes, response handshakes and stall stability.
    bit          stalled = 1'b0;
    logic [31:0] held_rdata;
    logic        held_illegal;
    always @(negedge clk) begin
        if (!rst) begin
            if (cyc_wr_en || ret_wr_en) begin
                check("one_strobe", 64'(cyc_wr_en & ret_wr_en), 64'h0);
                if (wr_q.size() == 0) begin
                    check("unexpected_strobe", 64'h1, 64'h0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("strobe_sel", 64'(ret_wr_en), 64'(w.is_ret));
                    check("cnt_wr_data", cnt_wr_data, w.data);
                end
            end else begin
                check("wr_data_idle", cnt_wr_data, 64'h0);
            end
            if (bus.rsp_valid) begin
                check("req_ready_busy", 64'(bus.req_ready), 64'h0);
                if (stalled) begin
                    check("hold_rdata", 64'(bus.rsp_rdata), 64'(held_rdata));
                    check("hold_illegal", 64'(bus.rsp_illegal), 64'(held_illegal));
                end
                if (bus.rsp_ready) begin
                    if (rsp_q.size() == 0) begin
                        check("unexpected_rsp", 64'h1, 64'h0);
                    end else begin
                        rsp_t r;
                        r = rsp_q.pop_front();
                        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(r.rdata));
                        check("rsp_illegal", 64'(bus.rsp_illegal), 64'(r.illegal));
                    end
                end
                stalled      = !bus.rsp_ready;
                held_rdata   = bus.rsp_rdata;
                held_illegal = bus.rsp_illegal;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic send(input logic [11:0] addr, input logic [1:0] op, input logic wr,
                        input logic [31:0] wd, input logic [63:0] a_cyc, input logic [63:0] a_ret,
                        input logic [63:0] b_cyc, input logic [63:0] b_ret, input bit chk_gap);
        rsp_t r;
        bit   dw;
        wr_t  w;
        int   lat;
        bit   got;
        model(addr, op, wr, wd, a_cyc, a_ret, b_cyc, b_ret, r, dw, w);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_op    = op;
        bus.req_wr    = wr;
        bus.req_wdata = wd;
        cyc_value     = a_cyc;
        ret_value     = a_ret;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("req_accept", 64'(got), 64'h1);
        if (!got) begin
            bus.req_valid = 1'b0;
            return;
        end
        rsp_q.push_back(r);
        if (dw) wr_q.push_back(w);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 12'($urandom);
        bus.req_wdata = $urandom;
        if (chk_gap) check("b2b_gap", 64'(cyc_n - last_hs), last_wr ? 64'd4 : 64'd3);
        last_hs = cyc_n;
        last_wr = dw;
        @(posedge clk);
        #1;
        cyc_value = b_cyc;
        ret_value = b_ret;
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) break;
        end
        check("rsp_latency", 64'(lat), dw ? 64'd3 : 64'd2);
    endtask

    initial begin
        rsp_t r;
        bit   dw;
        wr_t  w;
        bit   got;
        addrs = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82};
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_op    = '0;
        bus.req_wr    = 1'b0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        cyc_value     = '0;
        ret_value     = '0;

        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'h0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        check("rst_strobes", 64'({cyc_wr_en, ret_wr_en}), 64'h0);
        check("rst_wr_data", cnt_wr_data, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(bus.req_ready), 64'h1);
        check("post_rst_rdata", 64'(bus.rsp_rdata), 64'h0);

        send(12'hB00, 2'b01, 1'b1, 32'h1234_5678, 64'h0000_0002_0000_0010, 64'h55,
             64'h0000_0003_0000_0011, 64'h55, 1'b0);
        send(12'hB82, 2'b10, 1'b1, 32'h0000_00F0, 64'h99, 64'h0000_000F_1234_5678,
             64'h99, 64'h0000_000F_1234_5679, 1'b0);
        send(12'hC80, 2'b11, 1'b0, 32'h0000_FFFF, 64'hAAAA_AAAA_0000_0001, 64'h7,
             64'hAAAA_AAAA_0000_0001, 64'h7, 1'b0);
        send(12'hC02, 2'b01, 1'b1, 32'hDEAD_BEEF, 64'h1, 64'h2222_3333_4444_5555,
             64'h1, 64'h2222_3333_4444_5555, 1'b0);
        send(12'h7C0, 2'b10, 1'b0, 32'h0, 64'h1, 64'h2, 64'h1, 64'h2, 1'b0);
        send(12'hB80, 2'b00, 1'b1, 32'h1, 64'h1, 64'h2, 64'h1, 64'h2, 1'b0);

        hold_cnt = 9;
        send(12'hB02, 2'b10, 1'b1, 32'h0F0F_0000, 64'h5, 64'h1111_2222_3333_4444,
             64'h5, 64'h1111_2222_3333_4445, 1'b0);

        force_ready = 1'b1;
        send(12'hB00, 2'b01, 1'b0, 32'h1, 64'hA, 64'hB, 64'hA, 64'hB, 1'b0);
        send(12'hB80, 2'b10, 1'b0, 32'h1, 64'hC, 64'hD, 64'hC, 64'hD, 1'b1);
        send(12'hB02, 2'b01, 1'b1, 32'h77, 64'hE, 64'hF, 64'hE, 64'h10, 1'b1);
        send(12'hC82, 2'b11, 1'b0, 32'h3, 64'h11, 64'hFFFF_0000_0000_0000, 64'h11,
             64'hFFFF_0000_0000_0000, 1'b1);
        force_ready = 1'b0;

        // Reset asserted in the WRITE cycle.
        model(12'hB80, 2'b01, 1'b1, 32'hCAFE_F00D, 64'h0000_0001_0000_0002, 64'h0,
              64'h0000_0001_0000_0002, 64'h0, r, dw, w);
        wr_q.push_back(w);
        @(negedge clk);
        cyc_value = 64'h0000_0001_0000_0002;
        ret_value = 64'h0;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst_test_idle", 64'(got), 64'h1);
        bus.req_valid = 1'b1;
        bus.req_addr  = 12'hB80;
        bus.req_op    = 2'b01;
        bus.req_wr    = 1'b1;
        bus.req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("write_cycle_strobe", 64'(cyc_wr_en), 64'h1);
        #1 rst = 1'b1;
        #1;
        check("rst_kills_strobe", 64'({cyc_wr_en, ret_wr_en}), 64'h0);
        @(negedge clk);
        check("rst_mid_ready", 64'(bus.req_ready), 64'h0);
        check("rst_mid_valid", 64'(bus.rsp_valid), 64'h0);
        check("rst_mid_strobe", 64'({cyc_wr_en, ret_wr_en}), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", 64'(bus.req_ready), 64'h1);
        check("rst_release_valid", 64'(bus.rsp_valid), 64'h0);
        check("rst_release_strobe", 64'({cyc_wr_en, ret_wr_en}), 64'h0);

        for (int n = 0; n < 150; n++) begin
            logic [11:0] a;
            a = ($urandom_range(0, 3) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 7)];
            send(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                 {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        end

        for (int i = 0; i < 100; i++) begin
            if (rsp_q.size() == 0 && wr_q.size() == 0) break;
            @(negedge clk);
        end
        check("rsp_queue_drained", 64'(rsp_q.size()), 64'h0);
        check("wr_queue_drained", 64'(wr_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csr_counter_access.md
# csr_counter_access

CSR-side access unit for the 64-bit machine counters (cycle, instret) on the RV32IM core. It accepts one CSR instruction at a time from the execute stage and returns the addressed 32-bit half. For CSRRW/CSRRS/CSRRC it also computes the new value and drives a single-cycle 64-bit load strobe into the owning counter. It is the read/modify/write master for the counter blocks, sitting between the execute stage and `csr_fin` counters.

## Interface
- `COUNT_LEN`, 64, counter width; must equal 2*`XLEN`
- `XLEN`, 32, CSR data width
- `clk` input 1: core clock
- `rst` input 1: synchronous, active-high reset
- `req_valid` input 1: CSR request valid
- `req_ready` output 1: block idle, request accepted when `req_valid && req_ready`
- `req_addr` input 12: CSR address
- `req_op` input 2: 01 RW, 10 RS, 11 RC, 00 reserved (illegal)
- `req_wdata` input XLEN: rs1 value or zero-extended uimm
- `req_wr` input 1: write intended; 0 for RS/RC with rs1=x0/uimm=0
- `cyc_value` input COUNT_LEN: live mcycle
- `ret_value` input COUNT_LEN: live minstret
- `cyc_wr_en` output 1: one-cycle load strobe to cycle counter
- `ret_wr_en` output 1: one-cycle load strobe to instret counter
- `cnt_wr_data` output COUNT_LEN: full 64-bit load value
- `rsp_valid` output 1: response valid, held until `rsp_ready`
- `rsp_ready` input 1: consumer accepts response
- `rsp_rdata` output XLEN: old value of addressed half
- `rsp_illegal` output 1: illegal access; qualifies `rsp_valid`

## Operation
- Address map: 0xB00 mcycle lo, 0xB80 mcycleh, 0xB02 minstret lo, 0xB82 minstreth are read/write. 0xC00, 0xC80, 0xC02, 0xC82 are read-only shadows. Any other address is illegal.
- Illegal: unmapped address, `req_op`=00, or `req_wr`=1 to a read-only shadow. Illegal requests return `rsp_rdata`=0 with `rsp_illegal`=1 and never pulse a write strobe.
- FSM states:
  - IDLE: `req_ready`=1. On handshake, latch addr/op/wdata/wr and go to CAPTURE.
  - CAPTURE: sample the selected counter. Register the old half into `rsp_rdata`. Compute new half: RW=wdata, RS=old|wdata, RC=old&~wdata. Go to WRITE if legal and `req_wr`, else RESP.
  - WRITE: assert exactly one of `cyc_wr_en`/`ret_wr_en` for one cycle. `cnt_wr_data` = computed half in the addressed position, other half taken from the live counter input this cycle. Go to RESP.
  - RESP: `rsp_valid`=1. On `rsp_ready` go to IDLE.
- The write strobe overrides the counter's own increment in that cycle (the counter owns this priority). Carry from the low half into the high half in the WRITE cycle is lost by design.
- `cnt_wr_data` is 0 whenever no strobe is asserted.

## Timing
- Reset values: `req_ready`=0 during reset, 1 on the first cycle after. All other outputs 0. FSM in IDLE.
- Handshake at edge T. CAPTURE runs in cycle T+1. WRITE strobe in T+2 when a write occurs. `rsp_valid` from T+3 with a write, or T+2 without.
- Minimum throughput: one request per 3 cycles (no write) or 4 cycles (write), with `rsp_ready` tied high.
- `rsp_valid`, `rsp_rdata` and `rsp_illegal` stay stable while `rsp_ready`=0.
- `req_ready`=0 from CAPTURE through RESP. Requests presented then are not accepted and are not lost by the block; the requester holds them.
- Reset asserted in any state: next cycle IDLE, strobes 0, `rsp_valid` 0. No partial write is issued after reset.
- Read-value consistency is defined only per half. Software reads hi/lo/hi and retries on mismatch.

## Structure
- Package `csr_cnt_pkg`:
  - the eight CSR address localparams
  - `req_op` encodings
  - FSM state enum (IDLE, CAPTURE, WRITE, RESP)
  - counter-select encoding (CYC, RET)
- Sub-module `csr_cnt_addr_decode`: combinational decode of addr/op/wr into counter select, hi/lo select, read-only flag and illegal flag.

## Test plan
- RW 0x1234_5678 to 0xB00, `cyc_value`=0x0000_0002_0000_0010 → `rsp_rdata`=0x0000_0010. `cyc_wr_en` one cycle with `cnt_wr_data`={live hi, 0x1234_5678}. `ret_wr_en` stays 0.
- RS 0x0000_00F0 to 0xB82, `ret_value` hi=0x0000_000F → `rsp_rdata`=0x0000_000F. `ret_wr_en` with hi=0x0000_00FF, lo from live.
- RC with `req_wr`=0 on 0xC80, `cyc_value` hi=0xAAAA_AAAA → `rsp_rdata`=0xAAAA_AAAA at T+2. No strobe. `rsp_illegal`=0.
- RW to 0xC02, and separately a read of 0x7C0 → `rsp_illegal`=1, `rsp_rdata`=0, no strobe.
- `rsp_ready` low for 5 cycles → response fields held constant, `req_ready`=0 throughout. Back-to-back requests then complete at the stated spacing.
- Assert `rst` in the WRITE cycle → strobe deasserted next cycle, IDLE, `req_ready`=1 the cycle after release.
